sc_neuron_stream: RTL

- Bit-serial stochastic-computing neuron, parametrised successor of the fixed 3-input, 64-bit SC neuron.
- Consumes one bit per input channel per accepted cycle and multiplies each input by its weight with AND.
- Scales and adds the products with a deterministic round-robin MUX, then applies an N-state saturating-counter FSM (stochastic tanh/sigmoid).
- Emits the activation stream bit-serially plus a popcount of the output stream; sits between bitstream generators and the next layer or a stream-to-binary counter.

---
 rtl/sc_neuron_stream_if.sv | 30 +++
 rtl/sc_neuron_stream.sv | 115 +++++++++++
 2 files changed

// File: rtl/sc_neuron_stream_if.sv
// Stream-side bundle of the stochastic-computing neuron: bit inputs and start
// from the generators (master), activation stream and ones count back (slave).
interface sc_neuron_stream_if #(
    parameter int N_IN       = 3,
    parameter int STREAM_LEN = 64
);
    localparam int CNT_W = $clog2(STREAM_LEN + 1);

    logic             start;
    logic             bit_valid;
    logic [N_IN-1:0]  in_bits;
    logic [N_IN-1:0]  w_bits;
    logic [N_IN-1:0]  in_en;
    logic             b_bit;
    logic             busy;
    logic             out_valid;
    logic             out_bit;
    logic             done;
    logic [CNT_W-1:0] ones_cnt;

    modport master (
        output start, bit_valid, in_bits, w_bits, in_en, b_bit,
        input  busy, out_valid, out_bit, done, ones_cnt
    );

    modport slave (
        input  start, bit_valid, in_bits, w_bits, in_en, b_bit,
        output busy, out_valid, out_bit, done, ones_cnt
    );
endinterface

// File: rtl/sc_neuron_stream.sv
// Bit-serial SC neuron: AND-multiply, round-robin MUX add, saturating-counter tanh.
// Optional macro SC_NEURON_BIAS_EN interleaves the bias stream on odd-index output bits.
module sc_neuron_stream #(
    parameter int N_IN       = 3,
    parameter int STREAM_LEN = 64,
    parameter int FSM_STATES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sc_neuron_stream_if.slave  bus
);
    localparam int CNT_W = $clog2(STREAM_LEN + 1);
    localparam int IDX_W = $clog2(STREAM_LEN);
    localparam int SEL_W = $clog2(N_IN);
    localparam int LVL_W = $clog2(FSM_STATES);
    localparam logic [LVL_W-1:0] LVL_MID  = LVL_W'(FSM_STATES / 2);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FSM_STATES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STREAM_LEN - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] lvl_next;
    logic [N_IN-1:0]  prod_vec;
    logic             prod;
    logic             act;
    logic             emit;
    logic             accept;
    logic             last;
    logic             restart;
    logic             busy_int;
    logic             out_valid_q;
    logic             out_bit_q;
    logic             done_q;
    logic [CNT_W-1:0] ones_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_int = (state == RUN);
    end

    // Selecting one product per bit in fixed rotation gives a 1/N_IN scaled sum.
    always_comb begin
        accept   = (state == RUN) && bus.bit_valid;
        last     = accept && (idx == IDX_LAST);
        restart  = bus.start && (state != RUN);
        prod_vec = bus.in_bits & bus.w_bits & bus.in_en;
        prod     = prod_vec[sel];
        if (prod) lvl_next = (lvl == LVL_MAX) ? lvl : lvl + LVL_W'(1);
        else      lvl_next = (lvl == '0)      ? lvl : lvl - LVL_W'(1);
        act = (lvl_next >= LVL_MID);
`ifdef SC_NEURON_BIAS_EN
        emit = idx[0] ? bus.b_bit : act;
`else
        emit = act;
`endif
    end

`ifndef SC_NEURON_BIAS_EN
    logic unused_b_bit;
    always_comb unused_b_bit = bus.b_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '0;
            idx         <= '0;
            lvl         <= LVL_MID;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            done_q      <= 1'b0;
            ones_q      <= '0;
        end else begin
            out_valid_q <= accept;
            done_q      <= last;
            if (restart) begin
                sel    <= '0;
                idx    <= '0;
                lvl    <= LVL_MID;
                ones_q <= '0;
            end else if (accept) begin
                sel       <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
                idx       <= idx + IDX_W'(1);
                lvl       <= lvl_next;
                out_bit_q <= emit;
                ones_q    <= ones_q + CNT_W'(emit);
            end
        end
    end

    assign bus.busy      = busy_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.done      = done_q;
    assign bus.ones_cnt  = ones_q;
endmodule
